priority_encoder_8to3: RTL and testbench

PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

---
 rtl/priority_encoder_8to3.sv | 135 +++++++++++++
 tb/tb_priority_encoder_8to3.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_8to3.sv
// Debounced 8-to-3 priority encoder: a non-zero switch vector must hold steady for
// STABLE_CYCLES samples before its highest-set-bit index is presented until acknowledged.
module priority_encoder_8to3 #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic input_clock_1,
  input  logic input_reset_2,
  input  logic input_switch1_3,
  input  logic input_switch2_4,
  input  logic input_switch3_5,
  input  logic input_switch4_6,
  input  logic input_switch5_7,
  input  logic input_switch6_8,
  input  logic input_switch7_9,
  input  logic input_switch8_10,
  input  logic input_ack_11,
  output logic output_led1_0_12,
  output logic output_led2_0_13,
  output logic output_led3_0_14,
  output logic output_valid_0_15,
  output logic output_multi_0_16,
  output logic output_count1_0_17,
  output logic output_count2_0_18,
  output logic output_count3_0_19
);

  // Handshake: valid rises when a code is presented and holds, with code and multi
  // stable, until ack is sampled high on a rising edge; ack is ignored otherwise.

  typedef enum logic [1:0] {IDLE, QUALIFY, PRESENT, RELEASE} state_e;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] s;
  logic [7:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic [2:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;
  logic [2:0] enc;
  logic       many;

  assign s = {input_switch8_10, input_switch7_9, input_switch6_8, input_switch5_7,
              input_switch4_6, input_switch3_5, input_switch2_4, input_switch1_3};

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand_q[i]) enc = 3'(i);
    end
  end

  assign many = (cand_q & (cand_q - 8'd1)) != 8'd0;

  always_ff @(posedge input_clock_1 or posedge input_reset_2) begin
    if (input_reset_2) begin
      state_q <= IDLE;
      cand_q  <= 8'd0;
      cnt_q   <= 4'd0;
      code_q  <= 3'd0;
      count_q <= 3'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      count_q <= count_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    count_d = count_q;
    valid_d = valid_q;
    multi_d = multi_q;
    unique case (state_q)
      IDLE: begin
        if (s != 8'd0) begin
          cand_d  = s;
          cnt_d   = 4'd1;
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (s == 8'd0) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = 4'd1;
        end else if (cnt_q < STABLE) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          code_d  = enc;
          multi_d = many;
          valid_d = 1'b1;
          count_d = count_q + 3'd1;
          cnt_d   = 4'd0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (input_ack_11) begin
          valid_d = 1'b0;
          state_d = (s == 8'd0) ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        // Switches must all open before a new vector can qualify.
        if (s == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign output_led1_0_12   = code_q[0];
  assign output_led2_0_13   = code_q[1];
  assign output_led3_0_14   = code_q[2];
  assign output_valid_0_15  = valid_q;
  assign output_multi_0_16  = multi_q;
  assign output_count1_0_17 = count_q[0];
  assign output_count2_0_18 = count_q[1];
  assign output_count3_0_19 = count_q[2];

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Bench for priority_encoder_8to3: directed scenarios plus random switch activity,
// scored against a run-length reference model through an expected-result queue.
module tb_priority_encoder_8to3;

  localparam int STABLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw  = 8'd0;
  logic       ack = 1'b0;
  logic       led1, led2, led3, valid, multi, cnt1, cnt2, cnt3;
  logic [2:0] code, count;

  assign code  = {led3, led2, led1};
  assign count = {cnt3, cnt2, cnt1};

  priority_encoder_8to3 #(.STABLE_CYCLES(STABLE)) dut (
    .input_clock_1      (clk),
    .input_reset_2      (rst),
    .input_switch1_3    (sw[0]),
    .input_switch2_4    (sw[1]),
    .input_switch3_5    (sw[2]),
    .input_switch4_6    (sw[3]),
    .input_switch5_7    (sw[4]),
    .input_switch6_8    (sw[5]),
    .input_switch7_9    (sw[6]),
    .input_switch8_10   (sw[7]),
    .input_ack_11       (ack),
    .output_led1_0_12   (led1),
    .output_led2_0_13   (led2),
    .output_led3_0_14   (led3),
    .output_valid_0_15  (valid),
    .output_multi_0_16  (multi),
    .output_count1_0_17 (cnt1),
    .output_count2_0_18 (cnt2),
    .output_count3_0_19 (cnt3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected presentation packed as {count[2:0], multi, code[2:0]}.
  logic [6:0] exp_q[$];

  bit         m_pres;
  bit         m_rel;
  int         m_run;
  logic [7:0] m_prev;
  int         m_events;
  bit         exp_valid;

  task automatic model_reset();
    m_pres    = 0;
    m_rel     = 0;
    m_run     = 0;
    m_prev    = 8'd0;
    m_events  = 0;
    exp_valid = 0;
    exp_q.delete();
  endtask

  // A vector is presented once it has been sampled STABLE+1 times in a row while free;
  // after an ack the switches must read zero before the next vector counts.
  task automatic model_step(input logic [7:0] s, input logic a);
    int v;
    int idx;
    if (m_pres) begin
      if (a) begin
        m_pres = 0;
        m_rel  = (s != 8'd0);
      end
    end else if (m_rel) begin
      if (s == 8'd0) m_rel = 0;
    end else begin
      if (s == 8'd0) m_run = 0;
      else if (s == m_prev && m_run > 0) m_run++;
      else m_run = 1;
      m_prev = s;
      if (m_run == STABLE + 1) begin
        v   = int'(s);
        idx = 0;
        while (v > 1) begin
          v = v / 2;
          idx++;
        end
        m_events++;
        exp_q.push_back({3'(m_events % 8), ($countones(s) > 1) ? 1'b1 : 1'b0, 3'(idx)});
        m_pres = 1;
        m_run  = 0;
      end
    end
  endtask

  task automatic step(input logic [7:0] s, input logic a);
    sw  = s;
    ack = a;
    model_step(s, a);
    @(posedge clk);
    #1;
    exp_valid = m_pres;
  endtask

  task automatic hold(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0);
  endtask

  // Monitor: valid is checked every cycle; each rising valid pops one expectation.
  logic       valid_prev = 1'b0;
  logic [6:0] got;
  always @(negedge clk) begin
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      chk("valid", int'(valid), int'(exp_valid));
      if (valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_present", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("code",  int'(code),  int'(got[2:0]));
          chk("multi", int'(multi), int'(got[3]));
          chk("count", int'(count), int'(got[6:4]));
        end
      end
      valid_prev = valid;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_code"},  int'(code),  0);
    chk({tag, "_multi"}, int'(multi), 0);
    chk({tag, "_count"}, int'(count), 0);
  endtask

  logic [7:0] v;
  int         n;

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single switch held: presented after three edges and held while unacknowledged.
    hold(8'h10, 3);
    chk("basic_valid", int'(valid), 1);
    chk("basic_code",  int'(code),  4);
    chk("basic_multi", int'(multi), 0);
    chk("basic_count", int'(count), 1);
    hold(8'h10, 3);
    step(8'h00, 1'b1);

    // Multiple switches, ack while still pressed, activity during release ignored.
    hold(8'h85, 3);
    chk("multi_code", int'(code),  7);
    chk("multi_flag", int'(multi), 1);
    step(8'h85, 1'b1);
    chk("release_valid", int'(valid), 0);
    for (int i = 0; i < 5; i++) step(8'h02, i[0]);
    step(8'h00, 1'b0);
    hold(8'h02, 3);
    chk("rearm_code",  int'(code),  1);
    chk("rearm_count", int'(count), 3);

    // Ack with switches released goes straight to idle; next vector counts immediately.
    step(8'h00, 1'b1);
    hold(8'h20, 3);
    step(8'h00, 1'b1);

    // Bounce, then an abandoned qualification.
    step(8'h01, 1'b0);
    hold(8'h02, 3);
    step(8'h00, 1'b1);
    step(8'h08, 1'b1);
    step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Eight more presentations wrap the event counter.
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom_range(1, 255));
      hold(v, 3);
      step(8'h00, 1'b1);
    end

    // Asynchronous reset while presenting.
    hold(8'h40, 3);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    hold(8'h01, 3);
    chk("post_reset_count", int'(count), 1);
    step(8'h00, 1'b1);

    // Random activity with a small vector pool so repeats are frequent.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 4))
        0:       v = 8'h00;
        1:       v = 8'h80;
        2:       v = 8'h24;
        3:       v = 8'h01;
        default: v = 8'($urandom_range(1, 255));
      endcase
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) step(v, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
